elevator_scheduler: RTL and testbench

Clocked call scheduler for the 4-floor elevator. Latches floor-call buttons into a pending-request register and serves calls with a direction-holding (SCAN) policy. Drives the motor command from the floor sensors and times the door-open dwell. Sits between the board inputs (SW floor sensors, KEY call buttons) and the motor driver, replacing the combinational nearest-floor logic with a registered controller.

---
 rtl/elevator_pkg.sv | 93 +++++++++
 rtl/elevator_scheduler_door_timer.sv | 35 +++
 rtl/elevator_scheduler.sv | 147 ++++++++++++++
 tb/tb_elevator_scheduler.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types, motor encodings and floor helpers for the 4-floor elevator scheduler.
package elevator_pkg;

  localparam int unsigned NUM_FLOORS = 4;
  localparam int unsigned FLOOR_W    = $clog2(NUM_FLOORS);

  typedef logic [NUM_FLOORS-1:0] floor_vec_t;
  typedef logic [FLOOR_W-1:0]    floor_idx_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOVE_UP,
    S_MOVE_DOWN,
    S_DOOR_OPEN,
    S_FAULT
  } state_e;

  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } dir_e;

  localparam logic [1:0] MOTOR_STOP  = 2'b00;
  localparam logic [1:0] MOTOR_DOWN  = 2'b01;
  localparam logic [1:0] MOTOR_UP    = 2'b10;
  localparam logic [1:0] MOTOR_FAULT = 2'b11;

  typedef struct packed {
    state_e     state;
    dir_e       dir;
    floor_vec_t clr;
  } decision_t;

  function automatic logic is_onehot(floor_vec_t sw);
    return (sw != '0) && ((sw & (sw - floor_vec_t'(1))) == '0);
  endfunction

  function automatic logic is_multihot(floor_vec_t sw);
    return (sw & (sw - floor_vec_t'(1))) != '0;
  endfunction

  function automatic floor_idx_t onehot_to_idx(floor_vec_t sw);
    floor_idx_t idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (sw == (floor_vec_t'(1) << i)) idx = floor_idx_t'(i);
    end
    return idx;
  endfunction

  function automatic logic any_above(floor_vec_t pend, floor_idx_t idx);
    floor_vec_t at_or_below;
    at_or_below = (floor_vec_t'(2) << idx) - floor_vec_t'(1);
    return (pend & ~at_or_below) != '0;
  endfunction

  function automatic logic any_below(floor_vec_t pend, floor_idx_t idx);
    floor_vec_t below;
    below = (floor_vec_t'(1) << idx) - floor_vec_t'(1);
    return (pend & below) != '0;
  endfunction

  // SCAN: keep the current direction while calls remain ahead of the car.
  function automatic decision_t decide(floor_vec_t pend, floor_idx_t floor, dir_e dir);
    decision_t  d;
    floor_vec_t cur;
    cur     = floor_vec_t'(1) << floor;
    d.state = S_IDLE;
    d.dir   = dir;
    d.clr   = '0;
    if ((pend & cur) != '0) begin
      d.state = S_DOOR_OPEN;
      d.clr   = cur;
    end else if (any_above(pend, floor) && (dir == DIR_UP || !any_below(pend, floor))) begin
      d.state = S_MOVE_UP;
      d.dir   = DIR_UP;
    end else if (any_below(pend, floor)) begin
      d.state = S_MOVE_DOWN;
      d.dir   = DIR_DOWN;
    end
    return d;
  endfunction

  function automatic logic [1:0] motor_for(state_e s);
    case (s)
      S_MOVE_UP:   return MOTOR_UP;
      S_MOVE_DOWN: return MOTOR_DOWN;
      S_FAULT:     return MOTOR_FAULT;
      default:     return MOTOR_STOP;
    endcase
  endfunction

endpackage

// File: rtl/elevator_scheduler_door_timer.sv
// Door dwell timer: load arms a DOOR_CYCLES-cycle window, expire marks its last cycle.
module door_timer
  import elevator_pkg::*;
#(
  parameter int unsigned DOOR_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int unsigned   CW     = $clog2(DOOR_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(DOOR_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = RELOAD;
    end else if (en && count_q != '0) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign expire = en && !load && (count_q == '0);

endmodule

// File: rtl/elevator_scheduler.sv
// Registered SCAN call scheduler for the 4-floor elevator.
// Define ELEVATOR_WATCHDOG_EN to build the stalled-sensor watchdog.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int unsigned DOOR_CYCLES     = 50_000_000,
  parameter int unsigned WATCHDOG_CYCLES = 500_000_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [3:0] SW,
  input  logic [3:0] KEY,
  output logic [1:0] estado_motor,
  output logic       door_open,
  output logic [3:0] pending,
  output logic       fault
);

  state_e     state_q, state_d;
  dir_e       dir_q, dir_d;
  floor_idx_t last_floor_q, last_floor_d;
  floor_vec_t pending_q, pending_d;
  logic [1:0] estado_motor_q, estado_motor_d;
  logic       door_open_q, door_open_d;
  logic       fault_q, fault_d;

  floor_vec_t clr, cur;
  decision_t  dec;
  logic       sw_onehot, tmr_load, tmr_en, tmr_expire, wd_trip;

  door_timer #(.DOOR_CYCLES(DOOR_CYCLES)) u_door_timer (
    .clk    (CLOCK_50),
    .reset  (reset),
    .load   (tmr_load),
    .en     (tmr_en),
    .expire (tmr_expire)
  );

`ifdef ELEVATOR_WATCHDOG_EN
  logic [31:0] wd_cnt_q, wd_cnt_d;
  floor_vec_t  sw_prev_q;
  logic        moving;

  always_comb begin
    moving   = (state_q == S_MOVE_UP) || (state_q == S_MOVE_DOWN);
    wd_cnt_d = (moving && SW == sw_prev_q) ? wd_cnt_q + 32'd1 : '0;
    wd_trip  = moving && (wd_cnt_q >= WATCHDOG_CYCLES - 1);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wd_cnt_q  <= '0;
      sw_prev_q <= '0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      sw_prev_q <= SW;
    end
  end
`else
  logic unused_wd_limit;
  assign unused_wd_limit = ^WATCHDOG_CYCLES;
  assign wd_trip         = 1'b0;
`endif

  assign tmr_en = (state_q == S_DOOR_OPEN);

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    last_floor_d = last_floor_q;
    clr          = '0;
    tmr_load     = 1'b0;
    sw_onehot    = is_onehot(SW);
    cur          = floor_vec_t'(1) << last_floor_q;
    dec          = decide(pending_q, last_floor_q, dir_q);

    if (sw_onehot) last_floor_d = onehot_to_idx(SW);

    if (is_multihot(SW) || state_q == S_FAULT || wd_trip) begin
      state_d = S_FAULT;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d  = dec.state;
          dir_d    = dec.dir;
          clr      = dec.clr;
          tmr_load = (dec.state == S_DOOR_OPEN);
        end
        S_MOVE_UP, S_MOVE_DOWN: begin
          if (sw_onehot) begin
            if ((pending_q & SW) != '0) begin
              state_d  = S_DOOR_OPEN;
              clr      = SW;
              tmr_load = 1'b1;
            end else if ((state_q == S_MOVE_UP && SW[NUM_FLOORS-1]) ||
                         (state_q == S_MOVE_DOWN && SW[0])) begin
              state_d = S_IDLE;
            end
          end
        end
        S_DOOR_OPEN: begin
          // A call for the open floor keeps the door open and is never latched.
          clr = cur;
          if ((KEY & cur) != '0) begin
            tmr_load = 1'b1;
          end else if (tmr_expire) begin
            state_d  = dec.state;
            dir_d    = dec.dir;
            tmr_load = (dec.state == S_DOOR_OPEN);
          end
        end
        default: state_d = S_FAULT;
      endcase
    end

    pending_d      = (pending_q | KEY) & ~clr;
    estado_motor_d = motor_for(state_d);
    door_open_d    = (state_d == S_DOOR_OPEN);
    fault_d        = (state_d == S_FAULT);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q        <= S_IDLE;
      dir_q          <= DIR_UP;
      last_floor_q   <= '0;
      pending_q      <= '0;
      estado_motor_q <= MOTOR_STOP;
      door_open_q    <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      dir_q          <= dir_d;
      last_floor_q   <= last_floor_d;
      pending_q      <= pending_d;
      estado_motor_q <= estado_motor_d;
      door_open_q    <= door_open_d;
      fault_q        <= fault_d;
    end
  end

  assign estado_motor = estado_motor_q;
  assign door_open    = door_open_q;
  assign pending      = pending_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler with DOOR_CYCLES=4, WATCHDOG_CYCLES=20.
module tb_elevator_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] SW;
  logic [3:0] KEY;
  logic [1:0] estado_motor;
  logic       door_open;
  logic [3:0] pending;
  logic       fault;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  elevator_scheduler #(
    .DOOR_CYCLES     (4),
    .WATCHDOG_CYCLES (20)
  ) dut (
    .CLOCK_50     (clk),
    .reset        (reset),
    .SW           (SW),
    .KEY          (KEY),
    .estado_motor (estado_motor),
    .door_open    (door_open),
    .pending      (pending),
    .fault        (fault)
  );

  task automatic tick(input int unsigned n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [1:0] motor, input logic door,
                          input logic [3:0] pend, input logic flt);
    chk({tag, " motor"},   32'(estado_motor), 32'(motor));
    chk({tag, " door"},    32'(door_open),    32'(door));
    chk({tag, " pending"}, 32'(pending),      32'(pend));
    chk({tag, " fault"},   32'(fault),        32'(flt));
  endtask

  task automatic do_reset(input logic [3:0] sw);
    reset = 1'b1;
    SW    = sw;
    KEY   = 4'b0000;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    SW    = 4'b0001;
    KEY   = 4'b0000;
    tick(2);
    chk_outs("reset", 2'b00, 1'b0, 4'b0000, 1'b0);
    reset = 1'b0;
    tick(1);

    // Call to floor 3 from floor 1, passing unrequested floor 2.
    KEY = 4'b0100;
    tick(1);
    KEY = 4'b0000;
    chk_outs("latch", 2'b00, 1'b0, 4'b0100, 1'b0);
    tick(1);
    chk("start up", 32'(estado_motor), 32'h2);
    SW = 4'b0000; tick(1);
    chk("leave f1", 32'(estado_motor), 32'h2);
    SW = 4'b0010; tick(1);
    chk("pass f2", 32'(estado_motor), 32'h2);
    SW = 4'b0000; tick(1);
    SW = 4'b0100; tick(1);
    chk_outs("arrive f3", 2'b00, 1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("dwell f3", 32'(door_open), 32'h1);
    end
    tick(1);
    chk_outs("dwell end", 2'b00, 1'b0, 4'b0000, 1'b0);

    // SCAN hold: floor 4 is served before the later floor-1 call.
    do_reset(4'b0010);
    KEY = 4'b1000; tick(1);
    KEY = 4'b0000; tick(1);
    chk("up from f2", 32'(estado_motor), 32'h2);
    SW = 4'b0000; KEY = 4'b0001; tick(1);
    KEY = 4'b0000;
    chk("call below", 32'(pending), 32'h9);
    SW = 4'b0100; tick(1);
    chk("pass f3", 32'(estado_motor), 32'h2);
    SW = 4'b0000; tick(1);
    SW = 4'b1000; tick(1);
    chk_outs("arrive f4", 2'b00, 1'b1, 4'b0001, 1'b0);
    tick(3);
    chk("f4 dwell last", 32'(door_open), 32'h1);
    tick(1);
    chk_outs("reverse", 2'b01, 1'b0, 4'b0001, 1'b0);
    SW = 4'b0000; tick(1);
    SW = 4'b0001; tick(1);
    chk_outs("arrive f1", 2'b00, 1'b1, 4'b0000, 1'b0);
    tick(4);
    chk("f1 closed", 32'(door_open), 32'h0);

    // Same-floor call on dwell cycle 3 restarts the dwell: 3+4 cycles open.
    KEY = 4'b0100; tick(1);
    KEY = 4'b0000; tick(1);
    SW = 4'b0000; tick(1);
    SW = 4'b0100; tick(1);
    chk("restart c1", 32'(door_open), 32'h1);
    tick(2);
    chk("restart c3", 32'(door_open), 32'h1);
    KEY = 4'b0100; tick(1);
    KEY = 4'b0000;
    chk_outs("restart c4", 2'b00, 1'b1, 4'b0000, 1'b0);
    tick(3);
    chk("restart c7", 32'(door_open), 32'h1);
    tick(1);
    chk("restart closed", 32'(door_open), 32'h0);

    // Multi-hot sensors force a sticky fault.
    SW = 4'b0110; tick(1);
    chk_outs("fault entry", 2'b11, 1'b0, 4'b0000, 1'b1);
    SW = 4'b0100; KEY = 4'b0001; tick(1);
    KEY = 4'b0000;
    tick(5);
    chk_outs("fault sticky", 2'b11, 1'b0, 4'b0001, 1'b1);
    reset = 1'b1; tick(1);
    reset = 1'b0;
    chk_outs("fault reset", 2'b00, 1'b0, 4'b0000, 1'b0);

    // Stalled car with sensors stuck between floors.
    do_reset(4'b0001);
    SW = 4'b0000; KEY = 4'b1000; tick(1);
    KEY = 4'b0000; tick(1);
    chk("stall start", 32'(estado_motor), 32'h2);
`ifdef ELEVATOR_WATCHDOG_EN
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      tick(1);
      if (estado_motor == 2'b11) begin
        n = i;
        break;
      end
    end
    chk("wd latency", 32'(n), 32'd20);
    chk("wd fault", 32'(fault), 32'h1);
`else
    n = 100;
    tick(100);
    chk("no wd motor", 32'(estado_motor), 32'h2);
    chk("no wd fault", 32'(fault), 32'h0);
`endif
    reset = 1'b1; tick(1);
    reset = 1'b0;
    chk_outs("mid-move reset", 2'b00, 1'b0, 4'b0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
